// File: rtl/mem_stage_lsu_pkg.sv
// Shared MEM-stage types: EX/MEM and MEM/WB bundles, funct3 memop encodings, LSU state.
package mem_stage_lsu_pkg;

   localparam logic [2:0] MEMOP_B  = 3'b000;
   localparam logic [2:0] MEMOP_H  = 3'b001;
   localparam logic [2:0] MEMOP_W  = 3'b010;
   localparam logic [2:0] MEMOP_BU = 3'b100;
   localparam logic [2:0] MEMOP_HU = 3'b101;

   localparam logic [1:0] RESULTSRC_MEM = 2'b01;

   typedef struct packed {
      logic [31:0] pcplus4;
      logic [4:0]  rd;
      logic        regwrite;
      logic [1:0]  resultsrc;
      logic        memwrite;
      logic [31:0] aluresult;
      logic [31:0] writedata;
      logic [2:0]  memop;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] pcplus4;
      logic [4:0]  rd;
      logic        regwrite;
      logic [1:0]  resultsrc;
      logic [31:0] aluresult;
      logic [31:0] readdata;
   } mem_wb_t;

   typedef enum logic {
      StIdle,
      StResp
   } lsu_state_e;

   function automatic logic is_misaligned(input logic [2:0] memop, input logic [1:0] addr_lo);
      logic mis;
      unique case (memop)
         MEMOP_H, MEMOP_HU: mis = addr_lo[0];
         MEMOP_W:           mis = (addr_lo != 2'b00);
         default:           mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store byte enables/replication, load extraction/extension, misalignment.
module mem_stage_lsu_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [2:0]  memop,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] writedata,
   input  logic [31:0] rdata,
   output logic [3:0]  be_store,
   output logic [31:0] wdata_store,
   output logic [31:0] load_data,
   output logic        misalign
);

   logic [15:0] lane;

   always_comb begin
      misalign = is_misaligned(memop, addr_lo);
      lane     = 16'(rdata >> {addr_lo, 3'b000});

      unique case (memop)
         MEMOP_B: begin
            be_store    = 4'b0001 << addr_lo;
            wdata_store = {4{writedata[7:0]}};
         end
         MEMOP_H: begin
            be_store    = 4'b0011 << addr_lo;
            wdata_store = {2{writedata[15:0]}};
         end
         default: begin
            be_store    = 4'b1111;
            wdata_store = writedata;
         end
      endcase

      unique case (memop)
         MEMOP_B:  load_data = {{24{lane[7]}}, lane[7:0]};
         MEMOP_BU: load_data = {24'd0, lane[7:0]};
         MEMOP_H:  load_data = {{16{lane[15]}}, lane};
         MEMOP_HU: load_data = {16'd0, lane};
         default:  load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one outstanding word-bus access, stall generation and response watchdog.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  ex_mem_t     in,
   output mem_wb_t     out,
   output logic        stall_m,
   output logic        dreq_valid,
   input  logic        dreq_ready,
   output logic        dreq_we,
   output logic [31:0] dreq_addr,
   output logic [3:0]  dreq_be,
   output logic [31:0] dreq_wdata,
   input  logic        drsp_valid,
   input  logic [31:0] drsp_rdata,
   input  logic        drsp_err,
   output logic        misalign_m,
   output logic        fault_m
);

   lsu_state_e       state_q, state_d;
   logic [CNT_W-1:0] wdog_q, wdog_d;

   logic        is_load, is_store, is_mem, misalign, timeout;
   logic [3:0]  be_store;
   logic [31:0] wdata_store, load_data, readdata;

   mem_stage_lsu_align u_align (
      .memop       (in.memop),
      .addr_lo     (in.aluresult[1:0]),
      .writedata   (in.writedata),
      .rdata       (drsp_rdata),
      .be_store    (be_store),
      .wdata_store (wdata_store),
      .load_data   (load_data),
      .misalign    (misalign)
   );

   // A store flag wins if both load and store are flagged.
   assign is_store = in.memwrite;
   assign is_load  = (in.resultsrc == RESULTSRC_MEM) & ~in.memwrite;
   assign is_mem   = is_load | is_store;
   assign timeout  = (wdog_q == CNT_W'(TIMEOUT - 1));

   assign dreq_we    = is_store;
   assign dreq_addr  = {in.aluresult[31:2], 2'b00};
   assign dreq_be    = is_store ? be_store : 4'b1111;
   assign dreq_wdata = is_store ? wdata_store : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wdog_d     = wdog_q;
      dreq_valid = 1'b0;
      stall_m    = 1'b0;
      misalign_m = 1'b0;
      fault_m    = 1'b0;
      readdata   = '0;

      case (state_q)
         StIdle: begin
            if (is_mem && misalign) begin
               misalign_m = 1'b1;
            end else if (is_mem) begin
               dreq_valid = 1'b1;
               stall_m    = ~dreq_ready | is_load;
               if (dreq_ready && is_load) begin
                  state_d = StResp;
                  wdog_d  = '0;
               end
            end
         end
         StResp: begin
            if (drsp_valid) begin
               state_d = StIdle;
               wdog_d  = '0;
               if (drsp_err) fault_m  = 1'b1;
               else          readdata = load_data;
            end else if (timeout) begin
               // Abandon the access; a late response lands in IDLE and is ignored.
               state_d = StIdle;
               wdog_d  = '0;
               fault_m = 1'b1;
            end else begin
               stall_m = 1'b1;
               wdog_d  = wdog_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out.pcplus4   = in.pcplus4;
      out.rd        = in.rd;
      out.regwrite  = in.regwrite & ~misalign_m & ~fault_m;
      out.resultsrc = in.resultsrc;
      out.aluresult = in.aluresult;
      out.readdata  = readdata;
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the pipelined RV32I core; consumes the ex_mem_t bundle produced by the execute stage.
- Issues aligned word-bus requests to data memory with a valid/ready request channel and a valid response channel; aligns and extends load data.
- Drives stall_m to the hazard unit while an access is outstanding; presents mem_wb_t to the MEM/WB register.

Parameters:
- TIMEOUT, 64, maximum cycles allowed in RESP before the access is abandoned; must be ≥2.
- CNT_W, $clog2(TIMEOUT+1), watchdog counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in  in  ex_mem_t  EX/MEM register contents: pcplus4, rd, regwrite, resultsrc, memwrite, aluresult, writedata, memop[2:0] (funct3)
- out  out  mem_wb_t  pcplus4, rd, regwrite, resultsrc, aluresult, readdata
- stall_m  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble MEM/WB
- dreq_valid  out  1  request valid
- dreq_ready  in  1  request accepted
- dreq_we  out  1  1 = store
- dreq_addr  out  32  {aluresult[31:2], 2'b00}
- dreq_be  out  4  byte enables
- dreq_wdata  out  32  lane-replicated store data
- drsp_valid  in  1  load data valid; one-cycle pulse
- drsp_rdata  in  32  load word
- drsp_err  in  1  bus error, qualified by drsp_valid
- misalign_m  out  1  one-cycle pulse: misaligned access suppressed
- fault_m  out  1  one-cycle pulse: bus error or timeout

Behaviour:
- Load: resultsrc == 2'b01. Store: memwrite. memop uses RV32I funct3 encodings: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Misaligned: H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0. Suppress the request, pulse misalign_m, force out.regwrite = 0, no stall.
- States: IDLE, RESP. Reset: IDLE, watchdog 0, all outputs 0.
- IDLE, aligned memory op:
  - dreq_valid = 1 combinationally.
  - Not ready: stall_m = 1; stay in IDLE. The input is held because the upstream pipeline is stalled.
  - Ready with a store: complete in the same cycle; stall_m = 0.
  - Ready with a load: go to RESP; stall_m = 1.
- RESP:
  - dreq_valid = 0. Watchdog increments each cycle.
  - stall_m = ~drsp_valid & (watchdog ≠ TIMEOUT-1).
  - drsp_valid: readdata is formed combinationally from drsp_rdata; return to IDLE; clear watchdog.
  - drsp_valid with drsp_err: readdata = 0, out.regwrite = 0, pulse fault_m.
  - watchdog == TIMEOUT-1 without a response: same as an error. Any response arriving later is ignored while in IDLE.
- Store byte enables:
  - SB: 4'b0001 << addr[1:0]; wdata = {4{writedata[7:0]}}.
  - SH: 4'b0011 << addr[1:0]; wdata = {2{writedata[15:0]}}.
  - SW: 4'b1111; wdata = writedata.
- Load byte enables: 4'b1111 for all loads.
- Load extract: select the byte or half by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Non-memory ops: no request, stall_m = 0, readdata = 0.
- Pass-through: pcplus4, rd, regwrite, resultsrc and aluresult are copied to out, except where regwrite is forced to 0 as above.
- Async reset mid-access: return to IDLE immediately; dreq_valid drops; any later response is ignored.
- At most one outstanding access. dreq_* must hold stable while dreq_valid & ~dreq_ready.

Decomposition:
- Shared core package:
  - Add memop[2:0] to ex_mem_t.
  - Add mem_wb_t.
  - Add localparams for the funct3 memop encodings and RESULTSRC_MEM = 2'b01.
- One sub-module, lsu_align: combinational store lane/byte-enable generation, load extraction/extension, and misalign detection.

Test Plan:
- SW addr 0x100, writedata 0xDEADBEEF, dreq_ready = 1 → dreq_valid 1 cycle, be = 4'hF, wdata 0xDEADBEEF, stall_m = 0 throughout.
- SB addr 0x103, writedata 0x000000A5, ready delayed 3 cycles → stall_m = 1 for 3 cycles, be = 4'b1000, wdata 0xA5A5A5A5 held stable.
- LB addr 0x102, rdata 0x12F03456, drsp_valid 2 cycles after accept → stall 3 cycles total, readdata 0xFFFFFFF0. The same access as LBU gives 0x000000F0.
- LH addr 0x101 → no dreq_valid, misalign_m pulse, out.regwrite = 0, stall_m = 0.
- LW with no response, TIMEOUT = 8 → stall_m high 8 cycles, fault_m pulse, regwrite = 0. A late drsp_valid is ignored.
- rst_n asserted in RESP → IDLE, dreq_valid = 0, stall_m = 0; the next LW completes normally.
